fb_sram_arbiter: RTL and testbench

FB_SRAM_ARBITER -- requirements
Module: fb_sram_arbiter

---
 rtl/fb_sram_arbiter_if.sv | 40 ++++
 rtl/fb_sram_arbiter.sv | 131 +++++++++++++
 tb/tb_fb_sram_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_sram_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter, its two requesters and the SRAM pins.
// The slave modport is the arbiter's view; the master modport is the requester/SRAM side.
interface fb_sram_arbiter_if #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 16
);
   // display-fetch read port
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;

   // draw-engine write port
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_gnt;

   // SRAM pins
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_dq_out;
   logic [DATA_W-1:0] sram_dq_in;
   logic              sram_dq_oe;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_dq_in,
      output rd_gnt, rd_valid, rd_data, wr_gnt,
      output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
   );

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_dq_in,
      input  rd_gnt, rd_valid, rd_data, wr_gnt,
      input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
   );
endinterface

// File: rtl/fb_sram_arbiter.sv
// Two-port arbiter (display read / draw write) for an asynchronous SRAM.
// Each access is a 3-cycle slot: IDLE decision plus two strobe cycles.
module fb_sram_arbiter #(
   parameter int unsigned ADDR_W       = 20,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   fb_sram_arbiter_if.slave  bus
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD1,
      ST_RD2,
      ST_WR1,
      ST_WR2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_rd_gnt;
   logic              w_wr_gnt;
   logic [3:0]        r_starve;
   logic [3:0]        w_starve_nxt;

   logic [ADDR_W-1:0] r_sram_addr;
   logic [DATA_W-1:0] r_sram_dq_out;
   logic              r_sram_dq_oe;
   logic              r_sram_ce_n;
   logic              r_sram_oe_n;
   logic              r_sram_we_n;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rd_data;

   // Grants are gated by Reset so none can appear while reset is held.
   always_comb begin
      w_next   = r_state;
      w_rd_gnt = 1'b0;
      w_wr_gnt = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (Reset && bus.wr_req && (!bus.rd_req || (r_starve == LIMIT))) begin
               w_wr_gnt = 1'b1;
               w_next   = ST_WR1;
            end else if (Reset && bus.rd_req) begin
               w_rd_gnt = 1'b1;
               w_next   = ST_RD1;
            end
         end
         ST_RD1:  w_next = ST_RD2;
         ST_RD2:  w_next = ST_IDLE;
         ST_WR1:  w_next = ST_WR2;
         ST_WR2:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_starve_nxt = r_starve;
      if (!bus.wr_req || w_wr_gnt) begin
         w_starve_nxt = '0;
      end else if (r_starve < LIMIT) begin
         w_starve_nxt = r_starve + 4'd1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state  <= ST_IDLE;
         r_starve <= '0;
      end else begin
         r_state  <= w_next;
         r_starve <= w_starve_nxt;
      end
   end

   // Strobes are registered from the next state so they line up with the access cycles.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_sram_ce_n  <= 1'b1;
         r_sram_oe_n  <= 1'b1;
         r_sram_we_n  <= 1'b1;
         r_sram_dq_oe <= 1'b0;
      end else begin
         r_sram_ce_n  <= (w_next == ST_IDLE);
         r_sram_oe_n  <= !((w_next == ST_RD1) || (w_next == ST_RD2));
         r_sram_we_n  <= (w_next != ST_WR1);
         r_sram_dq_oe <= (w_next == ST_WR1) || (w_next == ST_WR2);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_sram_addr   <= '0;
         r_sram_dq_out <= '0;
      end else if (w_wr_gnt) begin
         r_sram_addr   <= bus.wr_addr;
         r_sram_dq_out <= bus.wr_data;
      end else if (w_rd_gnt) begin
         r_sram_addr   <= bus.rd_addr;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= (r_state == ST_RD2);
         if (r_state == ST_RD2) begin
            r_rd_data <= bus.sram_dq_in;
         end
      end
   end

   assign bus.rd_gnt      = w_rd_gnt;
   assign bus.wr_gnt      = w_wr_gnt;
   assign bus.rd_valid    = r_rd_valid;
   assign bus.rd_data     = r_rd_data;
   assign bus.sram_addr   = r_sram_addr;
   assign bus.sram_dq_out = r_sram_dq_out;
   assign bus.sram_dq_oe  = r_sram_dq_oe;
   assign bus.sram_ce_n   = r_sram_ce_n;
   assign bus.sram_oe_n   = r_sram_oe_n;
   assign bus.sram_we_n   = r_sram_we_n;

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Directed bench for fb_sram_arbiter: reset, single read/write, contention,
// back-to-back reads, reset abort of a write, plus a per-cycle protocol monitor.
module tb_fb_sram_arbiter;

   localparam int unsigned AW = 20;
   localparam int unsigned DW = 16;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [DW-1:0] wmem [0:4095];
   logic [4095:0] wvalid = '0;
   logic          prev_wgnt;
   logic [DW-1:0] exp_data [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

   fb_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   fb_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #10 Clk = ~Clk;

   function automatic logic [DW-1:0] init_val(input logic [11:0] a);
      case (a)
         12'h000: init_val = 16'h1111;
         12'h001: init_val = 16'h2222;
         12'h002: init_val = 16'h3333;
         12'h003: init_val = 16'h4444;
         12'h010: init_val = 16'h5555;
         12'h123: init_val = 16'hBEEF;
         default: init_val = 16'h0000;
      endcase
   endfunction

   // SRAM model: preloaded contents overlaid by completed writes
   logic [11:0] w_ma;
   assign w_ma = bus.sram_addr[11:0];
   assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n)
                           ? (wvalid[w_ma] ? wmem[w_ma] : init_val(w_ma)) : 16'h0000;

   always @(posedge Clk) begin
      if (Reset && !bus.sram_ce_n && !bus.sram_we_n) begin
         wmem[w_ma]   <= bus.sram_dq_out;
         wvalid[w_ma] <= 1'b1;
      end
   end

   task automatic check1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge Clk);
      #2;
   endtask

   // Per-cycle protocol monitor, sampled on the falling edge
   always @(negedge Clk) begin
      if (!Reset) begin
         prev_wgnt <= 1'b0;
      end else begin
         check1("mon_dual_grant", bus.rd_gnt & bus.wr_gnt, 1'b0);
         check1("mon_oe_dq_clash", !bus.sram_oe_n & bus.sram_dq_oe, 1'b0);
         check1("mon_we_only_wr1", bus.sram_we_n, !prev_wgnt);
         prev_wgnt <= bus.wr_gnt;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 20'h00123;
      bus.wr_req  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      #1 Reset = 1'b0;
      #3;
      // reset state, with a pending read that must not be granted
      check1("rst_rd_gnt", bus.rd_gnt, 1'b0);
      check1("rst_wr_gnt", bus.wr_gnt, 1'b0);
      check1("rst_rd_valid", bus.rd_valid, 1'b0);
      checkv("rst_rd_data", 32'(bus.rd_data), 32'h0);
      checkv("rst_sram_addr", 32'(bus.sram_addr), 32'h0);
      checkv("rst_dq_out", 32'(bus.sram_dq_out), 32'h0);
      check1("rst_dq_oe", bus.sram_dq_oe, 1'b0);
      check1("rst_ce_n", bus.sram_ce_n, 1'b1);
      check1("rst_oe_n", bus.sram_oe_n, 1'b1);
      check1("rst_we_n", bus.sram_we_n, 1'b1);
      bus.rd_req = 1'b0;
      @(posedge Clk);
      #8 Reset = 1'b1;
      next_cycle();
      #2;
      check1("idle_ce_n", bus.sram_ce_n, 1'b1);
      check1("idle_rd_gnt", bus.rd_gnt, 1'b0);

      // single read of 0x00123
      next_cycle();
      bus.rd_req = 1'b1; bus.rd_addr = 20'h00123;
      #2;
      check1("rd_gnt_T", bus.rd_gnt, 1'b1);
      check1("rd_wr_gnt_T", bus.wr_gnt, 1'b0);
      next_cycle();
      bus.rd_req = 1'b0; bus.rd_addr = 20'h0;
      #2;
      check1("rd_T1_ce_n", bus.sram_ce_n, 1'b0);
      check1("rd_T1_oe_n", bus.sram_oe_n, 1'b0);
      check1("rd_T1_we_n", bus.sram_we_n, 1'b1);
      check1("rd_T1_dq_oe", bus.sram_dq_oe, 1'b0);
      checkv("rd_T1_addr", 32'(bus.sram_addr), 32'h00123);
      check1("rd_T1_gnt", bus.rd_gnt, 1'b0);
      next_cycle(); #2;
      check1("rd_T2_oe_n", bus.sram_oe_n, 1'b0);
      check1("rd_T2_valid", bus.rd_valid, 1'b0);
      next_cycle(); #2;
      check1("rd_T3_valid", bus.rd_valid, 1'b1);
      checkv("rd_T3_data", 32'(bus.rd_data), 32'hBEEF);
      check1("rd_T3_oe_n", bus.sram_oe_n, 1'b1);
      check1("rd_T3_ce_n", bus.sram_ce_n, 1'b1);
      next_cycle(); #2;
      check1("rd_T4_valid", bus.rd_valid, 1'b0);
      checkv("rd_T4_data_hold", 32'(bus.rd_data), 32'hBEEF);

      // single write 0x1234 -> 0x00040
      next_cycle();
      bus.wr_req = 1'b1; bus.wr_addr = 20'h00040; bus.wr_data = 16'h1234;
      #2;
      check1("wr_gnt_T", bus.wr_gnt, 1'b1);
      check1("wr_rd_gnt_T", bus.rd_gnt, 1'b0);
      next_cycle();
      bus.wr_req = 1'b0; bus.wr_data = 16'hFFFF;
      #2;
      check1("wr_T1_we_n", bus.sram_we_n, 1'b0);
      check1("wr_T1_ce_n", bus.sram_ce_n, 1'b0);
      check1("wr_T1_oe_n", bus.sram_oe_n, 1'b1);
      check1("wr_T1_dq_oe", bus.sram_dq_oe, 1'b1);
      checkv("wr_T1_addr", 32'(bus.sram_addr), 32'h00040);
      checkv("wr_T1_dq_out", 32'(bus.sram_dq_out), 32'h1234);
      next_cycle(); #2;
      check1("wr_T2_we_n", bus.sram_we_n, 1'b1);
      check1("wr_T2_ce_n", bus.sram_ce_n, 1'b0);
      check1("wr_T2_dq_oe", bus.sram_dq_oe, 1'b1);
      checkv("wr_T2_dq_out", 32'(bus.sram_dq_out), 32'h1234);
      next_cycle(); #2;
      check1("wr_T3_dq_oe", bus.sram_dq_oe, 1'b0);
      check1("wr_T3_ce_n", bus.sram_ce_n, 1'b1);
      check1("wr_mem_040_valid", wvalid[12'h040], 1'b1);
      checkv("wr_mem_040", 32'(wmem[12'h040]), 32'h1234);

      // write request dropped before any grant opportunity
      next_cycle();
      bus.rd_req = 1'b1; bus.rd_addr = 20'h00010;
      #2;
      check1("drop_rd_gnt", bus.rd_gnt, 1'b1);
      next_cycle();
      bus.rd_req = 1'b0; bus.wr_req = 1'b1; bus.wr_addr = 20'h00077; bus.wr_data = 16'h7777;
      next_cycle();
      bus.wr_req = 1'b0;
      next_cycle(); #2;
      check1("drop_wr_gnt", bus.wr_gnt, 1'b0);
      check1("drop_rd_valid", bus.rd_valid, 1'b1);
      checkv("drop_rd_data", 32'(bus.rd_data), 32'h5555);
      next_cycle(); #2;
      check1("drop_no_write", wvalid[12'h077], 1'b0);

      // contention: reads win until the writer has waited STARVE_LIMIT cycles
      for (int c = 0; c <= 16; c++) begin
         next_cycle();
         if (c == 0) begin
            bus.rd_req = 1'b1; bus.rd_addr = 20'h00010;
            bus.wr_req = 1'b1; bus.wr_addr = 20'h00041; bus.wr_data = 16'hCAFE;
         end
         if (c == 10) bus.wr_req = 1'b0;
         if (c == 13) bus.rd_req = 1'b0;
         #2;
         check1($sformatf("cont_rd_gnt_c%0d", c), bus.rd_gnt,
                (c % 3 == 0) && (c != 9) && (c <= 12));
         check1($sformatf("cont_wr_gnt_c%0d", c), bus.wr_gnt, c == 9);
         check1($sformatf("cont_rd_valid_c%0d", c), bus.rd_valid,
                (c == 3) || (c == 6) || (c == 9) || (c == 15));
      end
      next_cycle(); #2;
      checkv("cont_mem_041", 32'(wmem[12'h041]), 32'hCAFE);

      // back-to-back reads of addresses 0..3
      for (int c = 0; c <= 13; c++) begin
         next_cycle();
         bus.rd_req  = (c < 10);
         bus.rd_addr = 20'(c / 3);
         #2;
         check1($sformatf("b2b_rd_gnt_c%0d", c), bus.rd_gnt, (c % 3 == 0) && (c < 12));
         check1($sformatf("b2b_rd_valid_c%0d", c), bus.rd_valid,
                (c % 3 == 0) && (c >= 3) && (c <= 12));
         if ((c % 3 == 0) && (c >= 3) && (c <= 12))
            checkv($sformatf("b2b_rd_data_c%0d", c), 32'(bus.rd_data), 32'(exp_data[c / 3 - 1]));
      end

      // reset asserted during WR1 abandons the write
      next_cycle();
      bus.wr_req = 1'b1; bus.wr_addr = 20'h00050; bus.wr_data = 16'h9999;
      #2;
      check1("abort_wr_gnt", bus.wr_gnt, 1'b1);
      next_cycle();
      bus.wr_req = 1'b0;
      #2;
      check1("abort_wr1_we_n", bus.sram_we_n, 1'b0);
      check1("abort_wr1_dq_oe", bus.sram_dq_oe, 1'b1);
      #2;
      Reset = 1'b0;
      bus.rd_req = 1'b1; bus.rd_addr = 20'h00123;
      #1;
      check1("abort_we_n_async", bus.sram_we_n, 1'b1);
      check1("abort_ce_n_async", bus.sram_ce_n, 1'b1);
      check1("abort_dq_oe_async", bus.sram_dq_oe, 1'b0);
      check1("abort_oe_n_async", bus.sram_oe_n, 1'b1);
      check1("abort_rd_gnt_in_rst", bus.rd_gnt, 1'b0);
      checkv("abort_addr_rst", 32'(bus.sram_addr), 32'h0);
      next_cycle(); #2;
      check1("abort_rd_gnt_held_rst", bus.rd_gnt, 1'b0);
      check1("abort_rd_valid_rst", bus.rd_valid, 1'b0);
      #4 Reset = 1'b1;
      #1;
      check1("post_rst_rd_gnt", bus.rd_gnt, 1'b1);
      next_cycle();
      bus.rd_req = 1'b0;
      #2;
      check1("post_rst_T1_oe_n", bus.sram_oe_n, 1'b0);
      check1("post_rst_T1_ce_n", bus.sram_ce_n, 1'b0);
      checkv("post_rst_T1_addr", 32'(bus.sram_addr), 32'h00123);
      next_cycle(); #2;
      check1("post_rst_T2_valid", bus.rd_valid, 1'b0);
      next_cycle(); #2;
      check1("post_rst_T3_valid", bus.rd_valid, 1'b1);
      checkv("post_rst_T3_data", 32'(bus.rd_data), 32'hBEEF);
      check1("abort_no_write_050", wvalid[12'h050], 1'b0);

      next_cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
